// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared widths, types and helpers for the fetch PC controller
//               and its SIMT / decode / IBuffer / ICache neighbours.
// Revision    : 1.0  initial release
// ============================================================================
package gpu_pkg;

  localparam int NUM_WARPS = 8;
  localparam int PC_W      = 10;
  localparam int PC_INC    = 4;
  localparam int WARPID_W  = $clog2(NUM_WARPS);
  localparam int TA_W      = NUM_WARPS * PC_W;

  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [WARPID_W-1:0]  wid_t;
  typedef logic [NUM_WARPS-1:0] wmask_t;

  // One fetch request as presented to the instruction cache.
  typedef struct packed {
    logic valid;
    wid_t wid;
    pc_t  pc;
  } fetch_req_t;

  // Extract warp w's target from the packed SIMT target bus.
  function automatic pc_t ta_slice(input logic [TA_W-1:0] ta, input int w);
    return ta[w*PC_W +: PC_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl_if
// Description : Bundle of the task-manager launch, SIMT fetch control, decode
//               redirect, IBuffer back-pressure and ICache request signals.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_pc_ctrl_if;
  import gpu_pkg::*;

  logic                Start_TM_IF;
  wid_t                WarpID_TM_IF;
  pc_t                 StartPC_TM_IF;
  wmask_t              UpdatePC_Qual1_SIMT_IF;
  wmask_t              UpdatePC_Qual2_SIMT_IF;
  wmask_t              Stall_SIMT_IF;
  logic [TA_W-1:0]     TA_SIMT_IF;
  wmask_t              UpdatePC_Qual3_ID_IF;
  pc_t                 TA_ID_IF;
  wmask_t              Exit_ID_IF;
  wmask_t              Full_IB_IF;
  logic                Valid_IF_ICache;
  pc_t                 PC_IF_ICache;
  wid_t                WarpID_IF_ICache;
  wmask_t              Active_IF;

  // Environment side: drives control, observes the fetch request.
  modport master (
    output Start_TM_IF, WarpID_TM_IF, StartPC_TM_IF,
    output UpdatePC_Qual1_SIMT_IF, UpdatePC_Qual2_SIMT_IF, Stall_SIMT_IF, TA_SIMT_IF,
    output UpdatePC_Qual3_ID_IF, TA_ID_IF, Exit_ID_IF, Full_IB_IF,
    input  Valid_IF_ICache, PC_IF_ICache, WarpID_IF_ICache, Active_IF
  );

  // Fetch controller side.
  modport slave (
    input  Start_TM_IF, WarpID_TM_IF, StartPC_TM_IF,
    input  UpdatePC_Qual1_SIMT_IF, UpdatePC_Qual2_SIMT_IF, Stall_SIMT_IF, TA_SIMT_IF,
    input  UpdatePC_Qual3_ID_IF, TA_ID_IF, Exit_ID_IF, Full_IB_IF,
    output Valid_IF_ICache, PC_IF_ICache, WarpID_IF_ICache, Active_IF
  );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8
// Description : Combinational 8-way round-robin pick. Searches upward from
//               the pointer, wrapping 7 -> 0, and returns the first request.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_8 (
  input  wire logic [7:0] request,
  input  wire logic [2:0] pointer,
  output logic            grant_valid,
  output logic [2:0]      grant_id
);

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;

  // Rotate so the pointer position lands at bit 0; the lowest set bit of
  // the rotated vector is then the distance to the winner.
  assign w_dbl = {request, request} >> pointer;
  assign w_rot = w_dbl[7:0];

  // Lowest set bit of the rotated request vector.
  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign grant_valid = |request;
  assign grant_id    = pointer + w_off;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Per-warp PC and active-bit store. Each cycle one eligible warp
//               is chosen round-robin and its PC is sent to the ICache; PCs
//               follow launch / exit / SIMT redirect / decode redirect /
//               sequential advance, in that priority.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_ctrl
  import gpu_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst,
  fetch_pc_ctrl_if.slave bus
);

  pc_t    r_pc [NUM_WARPS];
  wmask_t r_active;
  wid_t   r_ptr;
  logic   r_valid;
  pc_t    r_fpc;
  wid_t   r_fwid;

  wmask_t w_launch;
  wmask_t w_elig;
  wmask_t w_granted;
  logic   w_gvalid;
  wid_t   w_gid;
  pc_t    w_pc_nxt [NUM_WARPS];
  wmask_t w_act_nxt;

  // A warp touched by launch, exit or any redirect this cycle sits out of
  // arbitration so that the PC it would issue is never a stale one.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign w_launch[w]  = bus.Start_TM_IF && (bus.WarpID_TM_IF == wid_t'(w));
    assign w_elig[w]    = r_active[w]
                        & ~bus.Stall_SIMT_IF[w]
                        & ~bus.Full_IB_IF[w]
                        & ~bus.UpdatePC_Qual1_SIMT_IF[w]
                        & ~bus.UpdatePC_Qual2_SIMT_IF[w]
                        & ~bus.UpdatePC_Qual3_ID_IF[w]
                        & ~bus.Exit_ID_IF[w]
                        & ~w_launch[w];
    assign w_granted[w] = w_gvalid && (w_gid == wid_t'(w));
  end

  rr_arbiter_8 u_arb (
    .request     (w_elig),
    .pointer     (r_ptr),
    .grant_valid (w_gvalid),
    .grant_id    (w_gid)
  );

  // Next PC and active bit per warp, highest-priority event first.
  always_comb begin
    w_act_nxt = r_active;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_pc_nxt[i] = r_pc[i];
      if (w_launch[i]) begin
        w_pc_nxt[i]  = bus.StartPC_TM_IF;
        w_act_nxt[i] = 1'b1;
      end else if (bus.Exit_ID_IF[i]) begin
        w_act_nxt[i] = 1'b0;
      end else if (bus.UpdatePC_Qual1_SIMT_IF[i] || bus.UpdatePC_Qual2_SIMT_IF[i]) begin
        w_pc_nxt[i] = ta_slice(bus.TA_SIMT_IF, i);
      end else if (bus.UpdatePC_Qual3_ID_IF[i]) begin
        w_pc_nxt[i] = bus.TA_ID_IF;
      end else if (w_granted[i]) begin
        w_pc_nxt[i] = r_pc[i] + pc_t'(PC_INC);
      end
    end
  end

  // Warp PC and active-bit storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WARPS; i++) r_pc[i] <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) r_pc[i] <= w_pc_nxt[i];
      r_active <= w_act_nxt;
    end
  end

  // Registered fetch request and round-robin pointer; address and warp ID
  // hold across idle cycles so the ICache sees a stable bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_fpc   <= '0;
      r_fwid  <= '0;
      r_ptr   <= '0;
    end else begin
      r_valid <= w_gvalid;
      if (w_gvalid) begin
        r_fpc  <= r_pc[w_gid];
        r_fwid <= w_gid;
        r_ptr  <= w_gid + wid_t'(1);
      end
    end
  end

  assign bus.Valid_IF_ICache  = r_valid;
  assign bus.PC_IF_ICache     = r_fpc;
  assign bus.WarpID_IF_ICache = r_fwid;
  assign bus.Active_IF        = r_active;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Directed and randomized bench for fetch_pc_ctrl with a
//               warp-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_pc_ctrl;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle.
  logic       st;
  logic [2:0] swid;
  logic [9:0] spc;
  logic [7:0] q1, q2, q3, stl, ex, fl;
  logic [9:0] ta [8];
  logic [9:0] taid;

  // Reference model: warp table plus expected ICache request.
  int m_pc [8];
  bit m_act [8];
  int m_ptr;
  bit e_valid;
  int e_pc, e_wid;

  // Compare one observed value against the model's value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    st = 0; swid = 0; spc = 0; q1 = 0; q2 = 0; q3 = 0;
    stl = 0; ex = 0; fl = 0; taid = 0;
    for (int w = 0; w < 8; w++) ta[w] = 0;
  endtask

  task automatic drive();
    bus.Start_TM_IF            = st;
    bus.WarpID_TM_IF           = swid;
    bus.StartPC_TM_IF          = spc;
    bus.UpdatePC_Qual1_SIMT_IF = q1;
    bus.UpdatePC_Qual2_SIMT_IF = q2;
    bus.UpdatePC_Qual3_ID_IF   = q3;
    bus.Stall_SIMT_IF          = stl;
    bus.Exit_ID_IF             = ex;
    bus.Full_IB_IF             = fl;
    bus.TA_ID_IF               = taid;
    for (int w = 0; w < 8; w++) bus.TA_SIMT_IF[w*10 +: 10] = ta[w];
  endtask

  task automatic model_reset();
    for (int w = 0; w < 8; w++) begin m_pc[w] = 0; m_act[w] = 0; end
    m_ptr = 0; e_valid = 0; e_pc = 0; e_wid = 0;
  endtask

  // One clock of the warp-level behaviour for the currently driven inputs.
  task automatic model_step();
    int g;
    g = -1;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = (m_ptr + k) % 8;
      if (g < 0 && m_act[w] && !stl[w] && !fl[w] && !q1[w] && !q2[w] && !q3[w]
          && !ex[w] && !(st && swid == 3'(w)))
        g = w;
    end
    e_valid = (g >= 0);
    if (g >= 0) begin
      e_pc  = m_pc[g];
      e_wid = g;
      m_ptr = (g + 1) % 8;
    end
    for (int w = 0; w < 8; w++) begin
      if (st && swid == 3'(w)) begin m_pc[w] = spc; m_act[w] = 1; end
      else if (ex[w])          m_act[w] = 0;
      else if (q1[w] || q2[w]) m_pc[w] = ta[w];
      else if (q3[w])          m_pc[w] = taid;
      else if (w == g)         m_pc[w] = (m_pc[w] + PC_INC) % 1024;
    end
  endtask

  function automatic logic [7:0] m_act_vec();
    logic [7:0] v;
    for (int w = 0; w < 8; w++) v[w] = m_act[w];
    return v;
  endfunction

  // Apply stimulus, advance one clock, check at the following falling edge.
  task automatic tick();
    assert ($onehot0(q3)) else $fatal(1, "FAIL qual3_onehot stimulus=0x%0h required=onehot0", q3);
    drive();
    model_step();
    @(negedge clk);
    chk("valid",  32'(bus.Valid_IF_ICache),  32'(e_valid));
    chk("pc",     32'(bus.PC_IF_ICache),     32'(e_pc));
    chk("warpid", 32'(bus.WarpID_IF_ICache), 32'(e_wid));
    chk("active", 32'(bus.Active_IF),        32'(m_act_vec()));
  endtask

  // Assert reset between clock edges and check it takes effect at once.
  task automatic do_reset();
    rst = 1'b1;
    clr();
    drive();
    model_reset();
    #1;
    chk("rst_valid",  32'(bus.Valid_IF_ICache),  32'd0);
    chk("rst_active", 32'(bus.Active_IF),        32'd0);
    chk("rst_pc",     32'(bus.PC_IF_ICache),     32'd0);
    chk("rst_warpid", 32'(bus.WarpID_IF_ICache), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [9:0] exp_pc2 [5];
  logic [2:0] exp_wid2 [5];

  initial begin
    clr();
    drive();
    @(negedge clk);
    do_reset();

    // Warp 2 launched at 0x100 streams sequential PCs.
    clr(); st = 1; swid = 3'd2; spc = 10'h100; tick();
    chk("t1_launch_idle", 32'(bus.Valid_IF_ICache), 32'd0);
    clr(); tick();
    chk("t1_v0", 32'(bus.Valid_IF_ICache), 32'd1);
    chk("t1_w0", 32'(bus.WarpID_IF_ICache), 32'd2);
    chk("t1_p0", 32'(bus.PC_IF_ICache), 32'h100);
    tick(); chk("t1_p1", 32'(bus.PC_IF_ICache), 32'h104);
    tick(); chk("t1_p2", 32'(bus.PC_IF_ICache), 32'h108);

    // Warps 0,1,3 launched back to back interleave round-robin.
    do_reset();
    exp_pc2  = '{10'h000, 10'h040, 10'h080, 10'h004, 10'h044};
    exp_wid2 = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1};
    clr(); st = 1; swid = 3'd0; spc = 10'h000; tick();
    clr(); st = 1; swid = 3'd1; spc = 10'h040; tick();
    chk("t2_w0", 32'(bus.WarpID_IF_ICache), 32'(exp_wid2[0]));
    chk("t2_p0", 32'(bus.PC_IF_ICache), 32'(exp_pc2[0]));
    clr(); st = 1; swid = 3'd3; spc = 10'h080; tick();
    chk("t2_w1", 32'(bus.WarpID_IF_ICache), 32'(exp_wid2[1]));
    chk("t2_p1", 32'(bus.PC_IF_ICache), 32'(exp_pc2[1]));
    for (int i = 2; i < 5; i++) begin
      clr(); tick();
      chk("t2_w", 32'(bus.WarpID_IF_ICache), 32'(exp_wid2[i]));
      chk("t2_p", 32'(bus.PC_IF_ICache), 32'(exp_pc2[i]));
    end

    // Stall on warp 1 leaves warp 0 alone; warp 1 resumes at its own PC.
    do_reset();
    clr(); st = 1; swid = 3'd0; spc = 10'h000; tick();
    clr(); st = 1; swid = 3'd1; spc = 10'h040; stl = 8'h02; tick();
    chk("t3_p0", 32'(bus.PC_IF_ICache), 32'h000);
    clr(); stl = 8'h02; tick();
    chk("t3_p1", 32'(bus.PC_IF_ICache), 32'h004);
    clr(); stl = 8'h02; tick();
    chk("t3_p2", 32'(bus.PC_IF_ICache), 32'h008);
    chk("t3_w2", 32'(bus.WarpID_IF_ICache), 32'd0);
    clr(); tick();
    chk("t3_w3", 32'(bus.WarpID_IF_ICache), 32'd1);
    chk("t3_p3", 32'(bus.PC_IF_ICache), 32'h040);

    // SIMT redirect outranks decode redirect; no fetch in that cycle.
    do_reset();
    clr(); st = 1; swid = 3'd0; spc = 10'h010; tick();
    clr(); q1 = 8'h01; ta[0] = 10'h200; q3 = 8'h01; taid = 10'h300; tick();
    chk("t4_nofetch", 32'(bus.Valid_IF_ICache), 32'd0);
    clr(); tick();
    chk("t4_v", 32'(bus.Valid_IF_ICache), 32'd1);
    chk("t4_p", 32'(bus.PC_IF_ICache), 32'h200);

    // PC wraps from 0x3FC to 0x000.
    do_reset();
    clr(); st = 1; swid = 3'd5; spc = 10'h3FC; tick();
    clr(); tick();
    chk("t5_p0", 32'(bus.PC_IF_ICache), 32'h3FC);
    tick();
    chk("t5_p1", 32'(bus.PC_IF_ICache), 32'h000);
    chk("t5_w1", 32'(bus.WarpID_IF_ICache), 32'd5);

    // Exit of warp 2 clears its active bit and stops its fetches.
    do_reset();
    clr(); st = 1; swid = 3'd2; spc = 10'h100; tick();
    clr(); tick();
    clr(); ex = 8'h04; tick();
    chk("t6_active", 32'(bus.Active_IF[2]), 32'd0);
    chk("t6_novalid", 32'(bus.Valid_IF_ICache), 32'd0);
    for (int i = 0; i < 3; i++) begin
      clr(); tick();
      chk("t6_idle", 32'(bus.Valid_IF_ICache), 32'd0);
    end

    // Reset in the middle of traffic.
    clr(); st = 1; swid = 3'd4; spc = 10'h0A0; tick();
    clr(); tick(); tick();
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      clr();
      st   = ($urandom_range(0, 4) == 0);
      swid = 3'($urandom);
      spc  = 10'($urandom);
      stl  = 8'($urandom & $urandom);
      fl   = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) q1 = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) q2 = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 4) == 0) q3 = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ex = 8'(1 << $urandom_range(0, 7));
      taid = 10'($urandom);
      for (int w = 0; w < 8; w++) ta[w] = 10'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
